// File: rtl/peak_bin_finder_pkg.sv
// Shared definitions for the spectrum peak search and its neighbours
// (magnitude buffer, VGA path).
package peak_bin_finder_pkg;

   localparam int unsigned DEF_DATA_W = 64;
   localparam int unsigned DEF_ADDR_W = 10;
   localparam int unsigned DEF_RD_LAT = 2;

   typedef enum logic [1:0] {
      StIdle,
      StSweep,
      StDrain,
      StDone
   } state_e;

endpackage

// File: rtl/peak_bin_finder_rd_align.sv
// Delays the issued {read strobe, address} by the buffer read latency so each
// returning data word can be tagged with the bin it came from.
module peak_rd_align #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [ADDR_W-1:0] addr,
   output logic              dly_en,
   output logic [ADDR_W-1:0] dly_addr
);

   if (RD_LAT == 0) begin : g_lat_check
      $error("peak_rd_align: RD_LAT must be at least 1");
   end

   logic [RD_LAT-1:0][ADDR_W:0] pipe_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_q <= '0;
      end else begin
         pipe_q[0] <= {en, addr};
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign dly_en   = pipe_q[RD_LAT-1][ADDR_W];
   assign dly_addr = pipe_q[RD_LAT-1][ADDR_W-1:0];

endmodule

// File: rtl/peak_bin_finder.sv
// Sweeps a bin window of the magnitude buffer and reports the peak value, its
// bin and whether it clears a threshold.
module peak_bin_finder
   import peak_bin_finder_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned RD_LAT = DEF_RD_LAT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] bin_lo_i,
   input  logic [ADDR_W-1:0] bin_hi_i,
   input  logic [DATA_W-1:0] threshold_i,
   output logic [ADDR_W-1:0] rd_addr_o,
   output logic              rd_en_o,
   input  logic [DATA_W-1:0] rd_data_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] peak_value_o,
   output logic [ADDR_W-1:0] peak_index_o,
   output logic              peak_found_o
);

   localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   state_e            state_q;
   logic [ADDR_W-1:0] hi_q;
   logic [DATA_W-1:0] thr_q;
   logic [CNT_W-1:0]  drain_cnt_q;
   logic [DATA_W-1:0] max_q;
   logic [ADDR_W-1:0] idx_q;
   logic              have_q;

   logic              dly_en;
   logic [ADDR_W-1:0] dly_addr;
   logic              take;
   logic [DATA_W-1:0] max_d;
   logic [ADDR_W-1:0] idx_d;

   peak_rd_align #(
      .ADDR_W (ADDR_W),
      .RD_LAT (RD_LAT)
   ) u_align (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (rd_en_o),
      .addr     (rd_addr_o),
      .dly_en   (dly_en),
      .dly_addr (dly_addr)
   );

   // Strictly greater replaces, so ties keep the lowest bin.
   always_comb begin
      take  = dly_en && (!have_q || (rd_data_i > max_q));
      max_d = take ? rd_data_i : max_q;
      idx_d = take ? dly_addr : idx_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         hi_q         <= '0;
         thr_q        <= '0;
         drain_cnt_q  <= '0;
         max_q        <= '0;
         idx_q        <= '0;
         have_q       <= 1'b0;
         rd_addr_o    <= '0;
         rd_en_o      <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         peak_value_o <= '0;
         peak_index_o <= '0;
         peak_found_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (dly_en) begin
            max_q  <= max_d;
            idx_q  <= idx_d;
            have_q <= 1'b1;
         end
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  hi_q        <= bin_hi_i;
                  thr_q       <= threshold_i;
                  busy_o      <= 1'b1;
                  drain_cnt_q <= '0;
                  max_q       <= '0;
                  idx_q       <= '0;
                  have_q      <= 1'b0;
                  if (bin_lo_i <= bin_hi_i) begin
                     rd_addr_o <= bin_lo_i;
                     rd_en_o   <= 1'b1;
                     state_q   <= StSweep;
                  end else begin
                     done_o       <= 1'b1;
                     peak_value_o <= '0;
                     peak_index_o <= bin_lo_i;
                     peak_found_o <= 1'b0;
                     state_q      <= StDone;
                  end
               end
            end
            StSweep: begin
               // Stop on equality so a window ending at the top bin never wraps.
               if (rd_addr_o == hi_q) begin
                  rd_en_o <= 1'b0;
                  state_q <= StDrain;
               end else begin
                  rd_addr_o <= rd_addr_o + ADDR_W'(1);
               end
            end
            StDrain: begin
               if (drain_cnt_q == CNT_W'(RD_LAT - 1)) begin
                  done_o       <= 1'b1;
                  peak_value_o <= max_d;
                  peak_index_o <= idx_d;
                  peak_found_o <= (max_d > thr_q);
                  state_q      <= StDone;
               end else begin
                  drain_cnt_q <= drain_cnt_q + CNT_W'(1);
               end
            end
            StDone: begin
               busy_o  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
